// File: rtl/i2c_config_sequencer_if.sv
// i2c_config_sequencer_if: table, I2C engine and system status signals of the config sequencer.
interface i2c_config_sequencer_if;
    logic        start;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic        i2c_go;
    logic [7:0]  i2c_slave_address;
    logic [15:0] i2c_reg_data;
    logic [7:0]  i2c_byte_num;
    logic        i2c_end_ok;
    logic        i2c_ack_ok;
    logic        busy;
    logic        config_done;
    logic        config_err;
    logic [7:0]  err_index;
    logic [7:0]  nack_total;
    modport master (
        input  start, lut_data, i2c_end_ok, i2c_ack_ok,
        output lut_index, i2c_go, i2c_slave_address, i2c_reg_data, i2c_byte_num,
               busy, config_done, config_err, err_index, nack_total
    );
    modport slave (
        output start, lut_data, i2c_end_ok, i2c_ack_ok,
        input  lut_index, i2c_go, i2c_slave_address, i2c_reg_data, i2c_byte_num,
               busy, config_done, config_err, err_index, nack_total
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a slave-address/register-data table, launching one I2C write per entry
// with NACK retry, delay entries and a start/end handshake timeout.
module i2c_config_sequencer #(
    parameter int NUM_ENTRIES    = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int DELAY_SHIFT    = 10,
    parameter int BYTE_NUM       = 2
) (
    input logic                    pt_ck_i,
    input logic                    reset_i,
    i2c_config_sequencer_if.master bus_io
);
    localparam int DLY_W = 16 + DELAY_SHIFT;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);
    typedef enum logic [3:0] {IDLE, LOAD, LAUNCH, WAIT_START, WAIT_END, CHECK, DELAY, NEXT, DONE, ERROR} state_e;
    state_e           state_q;
    logic [1:0]       rdy_q;
    logic [7:0]       lut_index_q, addr_q, err_index_q, nack_q;
    logic [15:0]      data_q, tmo_q;
    logic [3:0]       retry_q;
    logic [DLY_W-1:0] dly_q;
    logic             go_q, busy_q, done_q, err_q;
    logic             restart, timeout;
    assign restart = bus_io.start && rdy_q[1] && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign timeout = tmo_q == TMO_LAST;
    always_ff @(posedge pt_ck_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rdy_q       <= '0;
            lut_index_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            err_index_q <= '0;
            nack_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            dly_q       <= '0;
            go_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // ready rises two cycles after reset release so the engine can park under GO high
            rdy_q <= {rdy_q[0], 1'b1};
            if (restart) begin
                state_q     <= LOAD;
                lut_index_q <= '0;
                busy_q      <= 1'b1;
                nack_q      <= '0;
                retry_q     <= '0;
                done_q      <= 1'b0;
                err_q       <= 1'b0;
            end else begin
                case (state_q)
                    LOAD: begin
                        addr_q  <= bus_io.lut_data[23:16];
                        data_q  <= bus_io.lut_data[15:0];
                        dly_q   <= DLY_W'(bus_io.lut_data[15:0]) << DELAY_SHIFT;
                        state_q <= bus_io.lut_data[23:16] == 8'hFF ? DELAY : LAUNCH;
                    end
                    LAUNCH: if (bus_io.i2c_end_ok) begin
                        go_q    <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= WAIT_START;
                    end
                    WAIT_START: begin
                        go_q  <= 1'b1;
                        tmo_q <= bus_io.i2c_end_ok ? tmo_q + 16'd1 : '0;
                        if (!bus_io.i2c_end_ok) state_q <= WAIT_END;
                        else if (timeout) begin
                            state_q     <= ERROR;
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            err_index_q <= lut_index_q;
                        end
                    end
                    WAIT_END: begin
                        tmo_q <= tmo_q + 16'd1;
                        if (bus_io.i2c_end_ok) state_q <= CHECK;
                        else if (timeout) begin
                            state_q     <= ERROR;
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            err_index_q <= lut_index_q;
                        end
                    end
                    CHECK: if (!bus_io.i2c_ack_ok) state_q <= NEXT;
                    else begin
                        nack_q <= nack_q + 8'(nack_q != 8'hFF);
                        if (retry_q < 4'(MAX_RETRY)) begin
                            retry_q <= retry_q + 4'd1;
                            state_q <= LAUNCH;
                        end else begin
                            state_q     <= ERROR;
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            err_index_q <= lut_index_q;
                        end
                    end
                    // a count of n holds DELAY for n cycles, with zero still costing one
                    DELAY: if (dly_q <= DLY_W'(1)) state_q <= NEXT;
                    else dly_q <= dly_q - DLY_W'(1);
                    NEXT: if (lut_index_q == LAST_IDX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        lut_index_q <= lut_index_q + 8'd1;
                        retry_q     <= '0;
                        state_q     <= LOAD;
                    end
                    default: ;
                endcase
            end
        end
    end
    assign bus_io.lut_index         = lut_index_q;
    assign bus_io.i2c_go            = go_q;
    assign bus_io.i2c_slave_address = addr_q;
    assign bus_io.i2c_reg_data      = data_q;
    assign bus_io.i2c_byte_num      = 8'(BYTE_NUM);
    assign bus_io.busy              = busy_q;
    assign bus_io.config_done       = done_q;
    assign bus_io.config_err        = err_q;
    assign bus_io.err_index         = err_index_q;
    assign bus_io.nack_total        = nack_q;
endmodule
